// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
//
// Registered, flow-controlled immediate generator sitting between decode and
// the register-read stage. Each accepted beat carries a 32-bit instruction and
// an immediate-type select. One cycle later the stage presents the XLEN-wide
// extended immediate together with the unchanged sideband tag (normally the PC).
//
// Two beat slots are used: the output slot and a skid slot behind it. in_ready
// comes straight from the skid-valid register, so there is no combinational
// path from out_ready to in_ready. The stage still sustains one beat per cycle
// under intermittent backpressure.
//
// Configuration macro:
//   CSR_IMM_EN  defined   : select 6 gives the zero-extended CSR address
//                           instr[31:20]. Select 7 gives the zero-extended
//                           uimm instr[19:15].
//               undefined : selects 6 and 7 produce out_imm = 0 and
//                           out_illegal = 1. The beat still flows normally.
//
// Parameters:
//   XLEN   datapath width, 32 or 64 only
//   TAG_W  sideband tag width
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset (clears data registers too)
//   flush        synchronous, drops every buffered beat (data registers kept)
//   in_valid     upstream beat valid
//   in_ready     stage can accept a beat this cycle (registered)
//   in_instr     raw instruction word
//   in_imm_src   0=I 1=Shamt 2=S 3=U 4=J 5=B 6=CSR address 7=CSR uimm
//   in_tag       sideband tag, returned unchanged
//   out_valid    output beat valid
//   out_ready    downstream accepts the output beat
//   out_imm      extended immediate
//   out_tag      tag of the output beat
//   out_illegal  in_imm_src is unsupported in this build (out_imm is then 0)
// -----------------------------------------------------------------------------
module imm_extend_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  // Width of the shift-amount field: 5 bits for RV32, 6 bits for RV64.
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [2:0] {
    SRC_I      = 3'd0,
    SRC_SHAMT  = 3'd1,
    SRC_S      = 3'd2,
    SRC_U      = 3'd3,
    SRC_J      = 3'd4,
    SRC_B      = 3'd5,
    SRC_CSRADR = 3'd6,
    SRC_CSRVAL = 3'd7
  } imm_src_e;

  // Every format is first assembled as a 32-bit signed value. It is then
  // sign-extended to XLEN. For RV64 this makes U-type extend from bit 31.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // ---------------------------------------------------------------------------
  // Immediate decode of the incoming beat
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_new;
  logic            ill_new;

  // NOTE: every signal written in always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    imm_new = '0;
    ill_new = 1'b0;
    case (imm_src_e'(in_imm_src))
      SRC_I:     imm_new = sext32({{20{in_instr[31]}}, in_instr[31:20]});
      SRC_SHAMT: imm_new = XLEN'(in_instr[20 +: SHW]);
      SRC_S:     imm_new = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      SRC_U:     imm_new = sext32({in_instr[31:12], 12'b0});
      SRC_J:     imm_new = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                   in_instr[20], in_instr[30:21], 1'b0});
      SRC_B:     imm_new = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                   in_instr[30:25], in_instr[11:8], 1'b0});
`ifdef CSR_IMM_EN
      SRC_CSRADR: imm_new = XLEN'(in_instr[31:20]);
      SRC_CSRVAL: imm_new = XLEN'(in_instr[19:15]);
`else
      SRC_CSRADR: ill_new = 1'b1;
      SRC_CSRVAL: ill_new = 1'b1;
`endif
      default:   ill_new = 1'b0;
    endcase
  end

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  // ---------------------------------------------------------------------------
  // Output slot and skid slot
  // ---------------------------------------------------------------------------
  logic             out_valid_q;
  logic [XLEN-1:0]  out_imm_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_ill_q;

  logic             skid_valid_q;
  logic [XLEN-1:0]  skid_imm_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic             skid_ill_q;

  logic accept;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q;

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from pre-edge values, which keeps the slots ordered.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: data registers are cleared here, not only the valid bits,
      // because out_imm/out_tag/out_illegal must read as zero after reset.
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else if (flush) begin
      // A beat offered in the same cycle is dropped as well.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      // Skid full implies the output slot is full and in_ready is low.
      // The older skid beat advances as soon as the output drains.
      if (out_ready) begin
        out_imm_q    <= skid_imm_q;
        out_tag_q    <= skid_tag_q;
        out_ill_q    <= skid_ill_q;
        skid_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        // Output slot is empty or draining this cycle, so the new beat takes it.
        out_valid_q <= 1'b1;
        out_imm_q   <= imm_new;
        out_tag_q   <= in_tag;
        out_ill_q   <= ill_new;
      end else begin
        skid_valid_q <= 1'b1;
        skid_imm_q   <= imm_new;
        skid_tag_q   <= in_tag;
        skid_ill_q   <= ill_new;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_ill_q;

endmodule
